bank_dispatcher: RTL and testbench

BANK_DISPATCHER -- requirements
Module: bank_dispatcher

---
 rtl/types_def.sv | 47 ++++
 rtl/dispatch_fifo2.sv | 69 ++++++
 rtl/bank_dispatcher.sv | 113 +++++++++++
 tb/tb_bank_dispatcher.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_def.sv
// Shared request, address and state types for the bank dispatcher.
// Request layout: 4-bit bank index ({bank_group, bank}) plus a 59-bit payload.
package types_def;

  localparam int bank_index_width = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } r_type;

  typedef struct packed {
    logic [1:0]  bank_group;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  column;
  } address_type;

  // Full request as it arrives from upstream (63 bits).
  typedef struct packed {
    r_type       req_type;
    address_type address;
    logic [31:0] data;
  } request;

  // Request as seen by a bank queue; the bank selection bits are implied (59 bits).
  typedef struct packed {
    r_type       req_type;
    logic [15:0] row;
    logic [9:0]  column;
    logic [31:0] data;
  } opt_request;

  typedef logic [15:0] banks_no;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dispatch_state_type;

  // Bank queue index, bank_group in the upper bits.
  function automatic logic [bank_index_width-1:0] bank_index(input address_type a);
    return {a.bank_group, a.bank};
  endfunction

endpackage

// File: rtl/dispatch_fifo2.sv
// Two-entry in-order request buffer with EMPTY/ONE/FULL control FSM.
// The head register only changes on a pop (or a push into EMPTY), so the
// head stays stable while it is being offered downstream.
module dispatch_fifo2
  import types_def::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  request             push_req,
  input  logic               pop,
  output request             head,
  output dispatch_state_type state
);

  dispatch_state_type state_reg, state_next;
  request             head_reg, head_next;
  request             tail_reg, tail_next;

  // State and storage registers; reset drops everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Next-state and storage update; a FULL buffer never sees a push.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = push_req;
          state_next = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_next  = push_req;
            state_next = FULL;
          end
          2'b01: state_next = EMPTY;
          2'b11: head_next = push_req;
          default: state_next = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign head  = head_reg;
  assign state = state_reg;

endmodule

// File: rtl/bank_dispatcher.sv
// Bank dispatcher: buffers requests two deep and offers the head to exactly
// one of 16 bank queues, strictly in arrival order. A saturating counter
// flags a head that stays blocked for STALL_LIMIT cycles.
// Optional feature: define DISPATCH_STATS_EN to add rd_count/wr_count
// outputs counting dispatched reads and writes.
module bank_dispatcher
  import types_def::*;
#(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  request     in_req,
  output banks_no    out_valid,
  input  banks_no    out_ready,
  output opt_request out_req,
  output logic       stall,
  output logic [1:0] occupancy
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  dispatch_state_type              state;
  request                          head;
  logic                            not_empty;
  logic                            push;
  logic                            pop;
  logic [bank_index_width-1:0]     head_index;
  logic [7:0]                      stall_cnt_reg;

  // in_ready depends on state only, so a pop cannot open the door to a
  // push in the same cycle while FULL.
  assign in_ready   = (state != FULL);
  assign push       = in_valid && in_ready;
  assign not_empty  = (state != EMPTY);
  assign head_index = bank_index(head.address);

  dispatch_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (in_req),
    .pop      (pop),
    .head     (head),
    .state    (state)
  );

  // One-hot decode of the head bank index.
  genvar gi;
  generate
    for (gi = 0; gi < $bits(banks_no); gi++) begin : g_valid
      assign out_valid[gi] = not_empty && (head_index == bank_index_width'(gi));
    end
  endgenerate

  // Only the ready bit of the addressed bank matters; out_valid is one-hot.
  assign pop = |(out_valid & out_ready);

  // Payload copy; the bank selection is carried by out_valid instead.
  always_comb begin
    out_req          = '0;
    out_req.req_type = head.req_type;
    out_req.row      = head.address.row;
    out_req.column   = head.address.column;
    out_req.data     = head.data;
  end

  // Entry count derived from the FSM state.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Consecutive blocked-head cycles, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst || pop || !not_empty) begin
      stall_cnt_reg <= 8'd0;
    end else if (stall_cnt_reg != 8'hFF) begin
      stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end
  end

  assign stall = (32'(stall_cnt_reg) >= STALL_LIMIT);

`ifdef DISPATCH_STATS_EN
  logic [15:0] rd_count_reg;
  logic [15:0] wr_count_reg;

  // Dispatched reads/writes, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_reg <= 16'd0;
      wr_count_reg <= 16'd0;
    end else if (pop) begin
      if (head.req_type == READ) rd_count_reg <= rd_count_reg + 16'd1;
      else                       wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_bank_dispatcher.sv
// Self-checking bench for bank_dispatcher (STALL_LIMIT = 4).
// Accepted requests are queued in a scoreboard; every dispatch pops the
// queue and is compared against the expected bank and payload.
module tb_bank_dispatcher;
  import types_def::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  request     in_req = '0;
  banks_no    out_valid;
  banks_no    out_ready = '0;
  opt_request out_req;
  logic       stall;
  logic [1:0] occupancy;
`ifdef DISPATCH_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  int          exp_rd = 0;
  int          exp_wr = 0;
`endif

  request sb[$];
  int     errors   = 0;
  int     checks   = 0;
  int     n_popped = 0;

  always #5 clk = ~clk;

  bank_dispatcher #(.STALL_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_req   (out_req),
    .stall     (stall),
    .occupancy (occupancy)
`ifdef DISPATCH_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  function automatic request make_req(input logic [1:0] bg, input logic [1:0] bk,
                                      input logic [15:0] row, input logic [9:0] col,
                                      input r_type t, input logic [31:0] d);
    request r;
    r.req_type           = t;
    r.address.bank_group = bg;
    r.address.bank       = bk;
    r.address.row        = row;
    r.address.column     = col;
    r.data               = d;
    return r;
  endfunction

  function automatic request rand_req();
    return make_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
                    10'($urandom), r_type'(1'($urandom_range(0, 1))), $urandom);
  endfunction

  function automatic banks_no onehot(input request r);
    return 16'd1 << {r.address.bank_group, r.address.bank};
  endfunction

  function automatic opt_request strip(input request r);
    opt_request o;
    o.req_type = r.req_type;
    o.row      = r.address.row;
    o.column   = r.address.column;
    o.data     = r.data;
    return o;
  endfunction

  // One clock: scoreboard compare mid-cycle, then record any accepted push.
  task automatic cycle(output bit accepted);
    request  exp;
    banks_no exp_valid;
    @(negedge clk);
    exp_valid = (sb.size() != 0) ? onehot(sb[0]) : 16'h0;
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL sb_out_valid: got %h expected %h", out_valid, exp_valid);
    end
    checks++;
    if (occupancy !== 2'(sb.size())) begin
      errors++;
      $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, sb.size());
    end
    if ((out_valid & out_ready) != 16'h0) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dispatch %h expected none", out_valid);
      end else begin
        exp = sb.pop_front();
        n_popped++;
        checks++;
        if (out_req !== strip(exp)) begin
          errors++;
          $display("FAIL sb_out_req: got %h expected %h", out_req, strip(exp));
        end
`ifdef DISPATCH_STATS_EN
        if (exp.req_type == READ) exp_rd++;
        else                      exp_wr++;
`endif
        $display("dispatch bank=%0d type=%0d row=%h col=%h data=%h",
                 {exp.address.bank_group, exp.address.bank}, exp.req_type,
                 exp.address.row, exp.address.column, exp.data);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(in_req);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
`ifdef DISPATCH_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 16'h0) begin errors++; $display("FAIL reset_out_valid: got %h expected 0", out_valid); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (out_req !== '0) begin errors++; $display("FAIL reset_out_req: got %h expected 0", out_req); end
  endtask

  task automatic test_single();
    bit acc;
    int base;
    base = n_popped;
    out_ready = '1;
    in_req = make_req(2'd2, 2'd1, 16'h00A5, 10'h3, WRITE, 32'hDEADBEEF);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 16'h0200) begin errors++; $display("FAIL single_valid: got %h expected 0200", out_valid); end
    checks++;
    if (out_req.row !== 16'h00A5 || out_req.column !== 10'h3 || out_req.req_type !== WRITE ||
        out_req.data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_fields: got %h expected row 00a5 col 003 write deadbeef", out_req);
    end
    cycle(acc);
    checks++;
    if (occupancy !== 2'd0 || n_popped != base + 1) begin
      errors++;
      $display("FAIL single_pop: got occ=%0d pops=%0d expected occ=0 pops=%0d", occupancy, n_popped - base, 1);
    end
  endtask

  task automatic test_backpressure();
    bit     acc;
    int     base;
    request reqs[3];
    base = n_popped;
    out_ready = '0;
    for (int i = 0; i < 3; i++) reqs[i] = rand_req();
    in_valid = 1'b1;
    in_req = reqs[0];
    cycle(acc);
    in_req = reqs[1];
    cycle(acc);
    in_req = reqs[2];
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL bp_full: got in_ready=%b occ=%0d expected 0 and 2", in_ready, occupancy);
    end
    cycle(acc);
    checks++;
    if (acc) begin errors++; $display("FAIL bp_third_held: got accepted expected held off"); end
    cycle(acc);
    out_ready = '1;
    for (int i = 0; i < 10 && (in_valid || sb.size() != 0); i++) begin
      cycle(acc);
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (n_popped != base + 3 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_drain: got pops=%0d occ=%0d expected pops=3 occ=0", n_popped - base, occupancy);
    end
  endtask

  task automatic test_hol_block();
    bit acc;
    int base;
    base = n_popped;
    out_ready = 16'h0040;
    in_valid = 1'b1;
    in_req = make_req(2'd1, 2'd1, 16'h1111, 10'h11, READ, 32'h55555555);
    cycle(acc);
    in_req = make_req(2'd1, 2'd2, 16'h2222, 10'h22, WRITE, 32'h66666666);
    cycle(acc);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 16'h0020 || n_popped != base) begin
        errors++;
        $display("FAIL hol_blocked: got valid=%h pops=%0d expected 0020 and 0", out_valid, n_popped - base);
      end
      cycle(acc);
    end
    out_ready = 16'h0060;
    for (int i = 0; i < 6 && sb.size() != 0; i++) cycle(acc);
    checks++;
    if (n_popped != base + 2) begin
      errors++;
      $display("FAIL hol_release: got pops=%0d expected 2", n_popped - base);
    end
  endtask

  task automatic test_stall();
    bit acc;
    out_ready = '0;
    in_valid = 1'b1;
    in_req = make_req(2'd0, 2'd3, 16'h0BAD, 10'h1F, READ, 32'h12345678);
    cycle(acc);
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle(acc);
      checks++;
      if (stall !== (i >= 4)) begin
        errors++;
        $display("FAIL stall_after_%0d_blocked: got %b expected %b", i, stall, (i >= 4));
      end
    end
    out_ready = '1;
    cycle(acc);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_after_pop: got %b expected 0", stall); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int base;
    base = n_popped;
    out_ready = '1;
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_req = rand_req();
      if (i > 0) begin
        checks++;
        if (occupancy !== 2'd1) begin
          errors++;
          $display("FAIL b2b_occupancy_%0d: got %0d expected 1", i, occupancy);
        end
      end
      cycle(acc);
      checks++;
      if (!acc) begin errors++; $display("FAIL b2b_accept_%0d: got rejected expected accepted", i); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4 && sb.size() != 0; i++) cycle(acc);
    checks++;
    if (n_popped != base + 11) begin
      errors++;
      $display("FAIL b2b_dispatched: got %0d expected 11", n_popped - base);
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
      errors++;
      $display("FAIL b2b_stats: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_count, wr_count, exp_rd, exp_wr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit acc;
    out_ready = '0;
    in_valid = 1'b1;
    in_req = rand_req();
    cycle(acc);
    in_req = rand_req();
    cycle(acc);
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL rmid_fill: got %0d expected 2", occupancy); end
    rst = 1'b1;
    in_req = rand_req();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
`ifdef DISPATCH_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
    checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_stats: got rd=%0d wr=%0d expected 0 0", rd_count, wr_count);
    end
`endif
    checks++;
    if (out_valid !== 16'h0 || in_ready !== 1'b1 || occupancy !== 2'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rmid_state: got valid=%h ready=%b occ=%0d stall=%b expected 0 1 0 0",
               out_valid, in_ready, occupancy, stall);
    end
    checks++;
    if (out_req !== '0) begin errors++; $display("FAIL rmid_out_req: got %h expected 0", out_req); end
    out_ready = '1;
    cycle(acc);
    cycle(acc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_hol_block();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
